flex_timer: RTL and testbench

Programmable down-counting timer, the countdown counterpart of the up-counting `flex_counter`. It loads a start value, decrements on each qualified tick, and signals expiry. It runs either one-shot or periodic (auto-reload). It sits beside `flex_counter` in timing and control paths, where a block needs "wait N enabled cycles, then act" rather than a running count.

---
 rtl/flex_timer.sv | 79 +++++++
 tb/tb_flex_timer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/flex_timer.sv
// flex_timer: programmable down-counting timer with one-shot and periodic
// (auto-reload) modes.
//
// Ports:
//   clk          system clock, rising edge
//   n_rst        asynchronous reset, active low
//   start        load load_val and begin/restart the countdown (ignored if load_val==0)
//   stop         abort and return to idle (wins over start and tick_enable)
//   tick_enable  decrement qualifier, only honoured while running
//   periodic     1 = reload on expiry, 0 = one-shot; sampled at the expiry edge
//   load_val     countdown start value, NUM_BITS wide
//   count_out    remaining count (registered)
//   expire_flag  one-cycle pulse on each expiry (registered)
//   busy         high while running
//   done         high after a one-shot expiry until start or stop
module flex_timer #(
  parameter int NUM_BITS = 4
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                start,
  input  logic                stop,
  input  logic                tick_enable,
  input  logic                periodic,
  input  logic [NUM_BITS-1:0] load_val,
  output logic [NUM_BITS-1:0] count_out,
  output logic                expire_flag,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;

  localparam logic [NUM_BITS-1:0] ONE = NUM_BITS'(1);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= IDLE;
      count_out   <= '0;
      expire_flag <= 1'b0;
    end else begin
      // expire_flag is a pulse: cleared unless an expiry happens this edge
      expire_flag <= 1'b0;
      if (stop) begin
        state     <= IDLE;
        count_out <= '0;
      end else if (start && (load_val != '0)) begin
        // A start while running restarts the count without an expiry
        state     <= RUN;
        count_out <= load_val;
      end else if ((state == RUN) && tick_enable) begin
        if (count_out > ONE) begin
          count_out <= count_out - ONE;
        end else begin
          // Terminal value is 1, so the count never underflows
          expire_flag <= 1'b1;
          if (periodic && (load_val != '0)) begin
            count_out <= load_val;
          end else begin
            // One-shot, or a periodic reload with an illegal zero value
            count_out <= '0;
            state     <= DONE;
          end
        end
      end
    end
  end

  // Status decoded straight from the state register; no input-to-output path
  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_flex_timer.sv
// Directed, table-driven testbench for flex_timer (NUM_BITS = 4).
module tb_flex_timer;

  logic       clk;
  logic       n_rst;
  logic       start;
  logic       stop;
  logic       tick_enable;
  logic       periodic;
  logic [3:0] load_val;
  logic [3:0] count_out;
  logic       expire_flag;
  logic       busy;
  logic       done;

  int tests_run = 0;
  int tests_failed = 0;

  flex_timer #(.NUM_BITS(4)) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .start       (start),
    .stop        (stop),
    .tick_enable (tick_enable),
    .periodic    (periodic),
    .load_val    (load_val),
    .count_out   (count_out),
    .expire_flag (expire_flag),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       st;
    logic       sp;
    logic       te;
    logic       per;
    logic [3:0] lv;
    logic [3:0] cnt;
    logic       exp;
    logic       bsy;
    logic       dn;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic st, input logic sp, input logic te,
                              input logic per, input logic [3:0] lv,
                              input logic [3:0] cnt, input logic exp,
                              input logic bsy, input logic dn);
    vec_t v;
    v.st = st; v.sp = sp; v.te = te; v.per = per; v.lv = lv;
    v.cnt = cnt; v.exp = exp; v.bsy = bsy; v.dn = dn;
    return v;
  endfunction

  task automatic check(input string name, input int actual, input int expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] cnt, input logic exp,
                           input logic bsy, input logic dn);
    check({tag, ".count_out"},   int'(count_out),   int'(cnt));
    check({tag, ".expire_flag"}, int'(expire_flag), int'(exp));
    check({tag, ".busy"},        int'(busy),        int'(bsy));
    check({tag, ".done"},        int'(done),        int'(dn));
  endtask

  // Drive inputs just after an edge, then sample 1 time unit after the next edge
  task automatic drive(input logic st, input logic sp, input logic te,
                       input logic per, input logic [3:0] lv);
    start = st; stop = sp; tick_enable = te; periodic = per; load_val = lv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    start = 0; stop = 0; tick_enable = 0; periodic = 0; load_val = 0;
    n_rst = 0;
    #1;
    check_all("reset_async", 4'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_rst = 1;
    check_all("reset_state", 4'd0, 1'b0, 1'b0, 1'b0);

    //                st sp te per lv     cnt exp bsy dn
    // One-shot, N=3
    vecs.push_back(mk(1, 0, 1, 0, 4'd3,  4'd3, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 4'd3,  4'd2, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 4'd3,  4'd1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 4'd3,  4'd0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 4'd3,  4'd0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 4'd3,  4'd0, 0, 0, 1));
    // Periodic, N=3, then periodic dropped mid-count
    vecs.push_back(mk(1, 0, 1, 1, 4'd3,  4'd3, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 1, 4'd3,  4'd2, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 1, 4'd3,  4'd1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 1, 4'd3,  4'd3, 1, 1, 0));
    vecs.push_back(mk(0, 0, 1, 1, 4'd3,  4'd2, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 1, 4'd3,  4'd1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 1, 4'd3,  4'd3, 1, 1, 0));
    vecs.push_back(mk(0, 0, 1, 1, 4'd3,  4'd2, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 4'd3,  4'd1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 4'd3,  4'd0, 1, 0, 1));
    // Tick gating, N=5: hold at 4 for two cycles
    vecs.push_back(mk(1, 0, 1, 0, 4'd5,  4'd5, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 4'd5,  4'd4, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 4'd5,  4'd4, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 4'd5,  4'd4, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 4'd5,  4'd3, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 4'd5,  4'd2, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 4'd5,  4'd1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 4'd5,  4'd0, 1, 0, 1));
    // Restart in RUN at count 2 with load 6: no expiry
    vecs.push_back(mk(1, 0, 1, 0, 4'd3,  4'd3, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 4'd3,  4'd2, 0, 1, 0));
    vecs.push_back(mk(1, 0, 1, 0, 4'd6,  4'd6, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 4'd6,  4'd5, 0, 1, 0));
    // stop and start together: stop wins
    vecs.push_back(mk(1, 1, 1, 0, 4'd6,  4'd0, 0, 0, 0));
    // start with load 0 in IDLE: ignored
    vecs.push_back(mk(1, 0, 1, 0, 4'd0,  4'd0, 0, 0, 0));
    // N=1 one-shot, then start with load 0 in DONE: ignored
    vecs.push_back(mk(1, 0, 0, 0, 4'd1,  4'd1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 4'd1,  4'd0, 1, 0, 1));
    vecs.push_back(mk(1, 0, 1, 0, 4'd0,  4'd0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 4'd0,  4'd0, 0, 0, 0));
    // Periodic N=1: continuous expiry; zero reload value ends in DONE
    vecs.push_back(mk(1, 0, 1, 1, 4'd1,  4'd1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 1, 4'd1,  4'd1, 1, 1, 0));
    vecs.push_back(mk(0, 0, 1, 1, 4'd1,  4'd1, 1, 1, 0));
    vecs.push_back(mk(0, 0, 1, 1, 4'd0,  4'd0, 1, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 4'd0,  4'd0, 0, 0, 0));
    // load_val change during RUN does not disturb the count
    vecs.push_back(mk(1, 0, 0, 0, 4'd4,  4'd4, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 4'd9,  4'd3, 0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 4'd9,  4'd0, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].st, vecs[i].sp, vecs[i].te, vecs[i].per, vecs[i].lv);
      check_all($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].exp, vecs[i].bsy, vecs[i].dn);
    end

    // Max value: load 15 one-shot, continuous ticks; expiry exactly 15 edges later
    begin
      int edges;
      int exp_edge;
      bit seen;
      drive(1, 0, 1, 0, 4'd15);
      check_all("max_load", 4'd15, 1'b0, 1'b1, 1'b0);
      exp_edge = -1;
      seen = 0;
      for (edges = 1; edges <= 20; edges++) begin
        drive(0, 0, 1, 0, 4'd15);
        if (!seen && expire_flag) begin
          exp_edge = edges;
          seen = 1;
        end
        if (edges < 15)
          check($sformatf("max_count_e%0d", edges), int'(count_out), 15 - edges);
        else
          check($sformatf("max_hold_e%0d", edges), int'(count_out), 0);
      end
      check("max_expiry_edge", exp_edge, 15);
      check("max_done", int'(done), 1);
    end

    // Asynchronous reset mid-run at count 5
    drive(0, 1, 0, 0, 4'd0);
    drive(1, 0, 0, 0, 4'd5);
    check_all("pre_reset", 4'd5, 1'b0, 1'b1, 1'b0);
    start = 0;
    #2;
    n_rst = 0;
    #1;
    check_all("reset_mid_run", 4'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_rst = 1;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 1, 4'd5);
      check_all($sformatf("post_reset_tick%0d", i), 4'd0, 1'b0, 1'b0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global watchdog so the run always terminates
  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
